sat_mul_arbiter: RTL and testbench



---
 rtl/sat_mul_pkg.sv | 36 +++
 rtl/sat_mul4.sv | 19 +
 rtl/sat_mul_arbiter.sv | 127 ++++++++++++
 tb/tb_sat_mul_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sat_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_mul_pkg
// Description : Shared widths, saturation limits and the 4x4 signed
//               saturating multiply helper for the shared multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_mul_pkg;

    localparam int OP_W    = 4;
    localparam int RES_W   = 6;
    localparam int SAT_MAX = 31;
    localparam int SAT_MIN = -32;

    // Returns {sat, data}; the 8-bit product cannot overflow for 4-bit operands.
    function automatic logic [RES_W:0] sat_mul_calc(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        logic signed [2*OP_W-1:0] v_a;
        logic signed [2*OP_W-1:0] v_b;
        logic signed [2*OP_W-1:0] v_p;
        v_a = {{OP_W{a[OP_W-1]}}, a};
        v_b = {{OP_W{b[OP_W-1]}}, b};
        v_p = v_a * v_b;
        if (v_p > SAT_MAX) begin
            return {1'b1, RES_W'(SAT_MAX)};
        end else if (v_p < SAT_MIN) begin
            return {1'b1, RES_W'(SAT_MIN)};
        end else begin
            return {1'b0, v_p[RES_W-1:0]};
        end
    endfunction

endpackage : sat_mul_pkg
`default_nettype wire

// File: rtl/sat_mul4.sv
`default_nettype none
// ============================================================================
// Module      : sat_mul4
// Description : Combinational 4x4 signed multiplier saturating to 6 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_mul4
    import sat_mul_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] c,
    output logic             sat
);

    assign {sat, c} = sat_mul_calc(a, b);

endmodule : sat_mul4
`default_nettype wire

// File: rtl/sat_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sat_mul_arbiter
// Description : Round-robin scheduler sharing one saturating 4x4 multiplier
//               among NREQ requesters, with a registered tagged response.
//               Optional saturation counter: define SAT_MUL_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_mul_arbiter
    import sat_mul_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ID_W   = $clog2(NREQ),
    parameter int STAT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_data,
    output logic                 rsp_sat,
`ifdef SAT_MUL_ARB_STATS_EN
    output logic [STAT_W-1:0]    sat_count,
`endif
    output logic [ID_W-1:0]      rsp_id
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_rsp_valid;
    logic [RES_W-1:0] r_rsp_data;
    logic             r_rsp_sat;
    logic [ID_W-1:0]  r_rsp_id;

    logic             w_can_accept;
    logic             w_found;
    logic             w_fire;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_ptr_next;
    logic [NREQ-1:0]  w_req_ready;
    logic [OP_W-1:0]  w_op_a;
    logic [OP_W-1:0]  w_op_b;
    logic [RES_W-1:0] w_prod;
    logic             w_prod_sat;

    // Reset forces the accept path off so no lane sees a spurious ready.
    assign w_can_accept = !rst && (!r_rsp_valid || rsp_ready);

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_fire     = w_can_accept && w_found;
    assign w_ptr_next = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    always_comb begin
        w_req_ready = '0;
        if (w_fire) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_op_a = req_a[int'(w_gnt_idx) * OP_W +: OP_W];
    assign w_op_b = req_b[int'(w_gnt_idx) * OP_W +: OP_W];

    sat_mul4 u_sat_mul4 (
        .a   (w_op_a),
        .b   (w_op_b),
        .c   (w_prod),
        .sat (w_prod_sat)
    );

    // A new handshake takes priority over draining, giving back-to-back results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_sat   <= 1'b0;
            r_rsp_id    <= '0;
        end else if (w_fire) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_prod;
            r_rsp_sat   <= w_prod_sat;
            r_rsp_id    <= w_gnt_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef SAT_MUL_ARB_STATS_EN
    logic [STAT_W-1:0] r_sat_count;

    // Sticky at all-ones so a long run never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_fire && w_prod_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + STAT_W'(1);
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_stat_w;
    assign w_unused_stat_w = (STAT_W > 0);
`endif

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_sat   = r_rsp_sat;
    assign rsp_id    = r_rsp_id;

endmodule : sat_mul_arbiter
`default_nettype wire

// File: tb/tb_sat_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sat_mul_arbiter
// Description : Self-checking bench for sat_mul_arbiter against an integer
//               reference model of the round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_mul_arbiter;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [5:0]        rsp_data;
    logic              rsp_sat;
    logic [ID_W-1:0]   rsp_id;
`ifdef SAT_MUL_ARB_STATS_EN
    logic [STAT_W-1:0] sat_count;
`endif

    always #5 clk = ~clk;

    sat_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .STAT_W(STAT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_sat   (rsp_sat),
`ifdef SAT_MUL_ARB_STATS_EN
        .sat_count (sat_count),
`endif
        .rsp_id    (rsp_id)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int              m_ptr;
    logic            m_valid;
    logic [5:0]      m_data;
    logic            m_sat;
    int              m_id;
    int              m_cnt;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] cap_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int p;
        logic [5:0] lo;
        ia = $signed(a);
        ib = $signed(b);
        p  = ia * ib;
        lo = p[5:0];
        if (p > 31)  return {1'b1, 6'b011111};
        if (p < -32) return {1'b1, 6'b100000};
        return {1'b0, lo};
    endfunction

    // One clock: check the combinational grant, advance the model, check the response.
    task automatic run_cycle();
        int         g;
        logic       can;
        logic [6:0] r;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        can = !rst && (!m_valid || rsp_ready);
        last_gnt = '0;
        if (can && g >= 0) last_gnt[g] = 1'b1;
        cap_rdy = req_ready;
        chk("req_ready", req_ready, last_gnt);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sat = 1'b0; m_id = 0; m_cnt = 0;
        end else if (last_gnt != '0) begin
            r       = ref_mul(req_a[g*4 +: 4], req_b[g*4 +: 4]);
            m_data  = r[5:0];
            m_sat   = r[6];
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NREQ;
            if (m_sat && m_cnt < (1 << STAT_W) - 1) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_sat", rsp_sat, m_sat);
        chk("rsp_id", rsp_id, m_id);
`ifdef SAT_MUL_ARB_STATS_EN
        chk("sat_count", sat_count, m_cnt);
`endif
        @(negedge clk);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] v;
        v = 4'($urandom);
        if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 0) ? 4'h8 : 4'h7;
        return v;
    endfunction

    logic [3:0] sa [4] = '{4'h8, 4'h8, 4'h4, 4'hD};
    logic [3:0] sb [4] = '{4'h8, 4'h7, 4'h8, 4'h5};
    logic [5:0] sd [4] = '{6'b011111, 6'b100000, 6'b100000, 6'b110001};
    logic       ss [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int         rr_ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [NREQ-1:0] one;
        one = 1;
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sat = 1'b0; m_id = 0; m_cnt = 0;
        last_gnt = '0;
        cap_rdy  = '0;

        // Reset with all lanes requesting
        rst = 1'b1; rsp_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*4 +: 4] = rand_op();
            req_b[i*4 +: 4] = rand_op();
        end
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Round-robin with all lanes valid
        for (int s = 0; s < 5; s++) begin
            run_cycle();
            chk("rr_order", cap_rdy, one << rr_ord[s]);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*4 +: 4] = rand_op();
                req_b[i*4 +: 4] = rand_op();
            end
        end

        // Saturation boundaries on lane 2
        req_valid = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            req_a[11:8] = sa[s];
            req_b[11:8] = sb[s];
            run_cycle();
            chk("sat_tbl_data", rsp_data, sd[s]);
            chk("sat_tbl_sat", rsp_sat, ss[s]);
        end

        // Backpressure with lanes 1 and 3
        req_valid = 4'b1010;
        req_a[7:4] = 4'h3; req_b[7:4] = 4'h5;
        req_a[15:12] = 4'hE; req_b[15:12] = 4'h6;
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) run_cycle();
        rsp_ready = 1'b1;
        for (int s = 0; s < 3; s++) run_cycle();

        // Single requester on lane 3
        req_valid = 4'b1000;
        for (int s = 0; s < 4; s++) begin
            req_a[15:12] = rand_op();
            req_b[15:12] = rand_op();
            run_cycle();
            chk("single_gnt", cap_rdy, 4'b1000);
        end

        // Random traffic that respects the hold-until-ready rule
        for (int s = 0; s < 300; s++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_gnt[i]) begin
                    req_valid[i]    = ($urandom_range(0, 2) != 0);
                    req_a[i*4 +: 4] = rand_op();
                    req_b[i*4 +: 4] = rand_op();
                end
            end
        end

        // Reset while a response is pending
        req_valid = 4'b0001; rsp_ready = 1'b0;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0; rsp_ready = 1'b1;
        run_cycle();

`ifdef SAT_MUL_ARB_STATS_EN
        // Sticky counter with STAT_W=2
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        req_valid = 4'b0001; req_a[3:0] = 4'h8; req_b[3:0] = 4'h8;
        for (int s = 0; s < 5; s++) run_cycle();
        chk("sat_sticky", sat_count, 3);
        rst = 1'b1;
        run_cycle();
        chk("sat_clear", sat_count, 0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sat_mul_arbiter
`default_nettype wire
